trigger_line_out: RTL and testbench
===================================

Name: trigger_line_out

Overview:
Output-side counterpart of the trigger input edge-detect path. It takes a single-cycle internal trigger pulse and drives a physical output line (strobe/trigger-out) with a programmable delay, pulse width and polarity. It sits between the exposure/trigger control logic and the line output buffer, in the same 72 MHz clk domain as the trigger input logic.

Parameters:
DELAY_WIDTH, 16, width of delay counter and iv_delay (cycles)
PULSE_WIDTH_BITS, 16, width of pulse-width counter and iv_width (cycles)

Ports:
clk  input  1  system clock, 72 MHz
rst_n  input  1  asynchronous reset, active-low
i_trigger  input  1  single-cycle trigger pulse, clk domain
i_line_en  input  1  1 = output enabled; 0 = line forced inactive and any pulse aborted
i_line_active  input  1  output polarity: 1 = active-high, 0 = active-low
iv_delay  input  DELAY_WIDTH  cycles from trigger acceptance to line assertion
iv_width  input  PULSE_WIDTH_BITS  active-level duration in cycles; 0 treated as 1
o_line  output  1  output line level, registered
o_busy  output  1  high while a pulse is pending or active
o_trigger_miss  output  1  one-cycle pulse when a trigger is dropped

Behaviour:
- Reset (rst_n low, async): state = IDLE, counters = 0, o_line = 0, o_busy = 0, o_trigger_miss = 0.
- First clock after reset release: o_line takes the inactive level (1 if i_line_active = 0).
- States: IDLE, DELAY, ACTIVE.
- IDLE:
  - i_trigger = 1 and i_line_en = 1 at edge T: latch iv_delay to dly_q and max(iv_width,1) to wid_q.
  - If dly_q = 0, go to ACTIVE; otherwise go to DELAY with delay counter = dly_q.
- DELAY: decrement each cycle. Go to ACTIVE on the edge where the counter reaches 1, so the line asserts exactly dly_q cycles later than for delay 0.
- ACTIVE: width counter loads wid_q, decrements each cycle, and returns to IDLE after wid_q cycles.
- Timing with D = latched delay, W = latched width (min 1), trigger sampled at edge T:
  - o_line is at the active level for the clk periods following edges T+1+D through T+D+W.
  - o_line is inactive from edge T+1+D+W.
  - o_busy = 1 from edge T+1 through edge T+D+W; o_busy = 0 from edge T+1+D+W.
- Output encoding: o_line is registered, o_line = (state == ACTIVE) XNOR i_line_active. Polarity changes take effect on the next edge, including mid-pulse.
- Config latching: iv_delay and iv_width are captured only at trigger acceptance; changes during DELAY or ACTIVE have no effect.
- Retrigger: a trigger while o_busy = 1 (DELAY or ACTIVE) is ignored and o_trigger_miss = 1 for one cycle on the next edge. There is no queueing.
- Same-cycle retrigger: a trigger sampled on the edge where ACTIVE ends (transition to IDLE) is a miss. The earliest accepted retrigger is at edge T+1+D+W.
- Disable: i_line_en = 0 in any state forces IDLE on the next edge and drives o_line inactive. o_busy drops on the same edge. Triggers while disabled are dropped without o_trigger_miss.
- Re-enable: requires a new trigger; no pending pulse is resumed.
- Reset mid-pulse: immediate return to reset values; the line is inactive after the first clock following release.
- Counters are unsigned, with no wrap. A delay of 2^DELAY_WIDTH-1 is valid; the width maximum is 2^PULSE_WIDTH_BITS-1.

Test Plan:
- Basic pulse: i_line_active = 1, iv_delay = 0, iv_width = 1, i_trigger at edge 10 -> o_line = 1 for exactly one cycle (edges 11 to 12), o_busy high edges 11 to 11, low from 12.
- Delay/width: iv_delay = 5, iv_width = 3, trigger at edge 20 -> o_line high edges 26 to 28, low at 29. Changing iv_width to 100 at edge 22 -> still 3 cycles.
- Width zero and polarity: iv_width = 0, i_line_active = 0, iv_delay = 2, trigger at edge 5 -> o_line idles 1, goes 0 for one cycle (edge 8), back to 1 at edge 9.
- Retrigger: iv_delay = 4, iv_width = 4, triggers at edges 10, 12, 18 and 19 -> only edge-10 pulse drives the line (edges 15 to 18). o_trigger_miss pulses after edges 12 and 18. The edge-19 trigger is accepted, giving a line high at edges 24 to 27.
- Abort: pulse in ACTIVE, i_line_en = 0 for one cycle -> o_line inactive and o_busy = 0 next edge. A trigger while disabled -> no o_trigger_miss, no pulse.
- Reset mid-operation: rst_n low asynchronously during DELAY -> o_line = 0 and o_busy = 0 immediately. After release with i_line_active = 0 -> o_line = 1 on first edge, no residual pulse.

Source files
------------

// File: rtl/trigger_line_out.sv
// Trigger-out line driver: turns a single-cycle internal trigger into a delayed,
// width-programmable pulse on a physical output line with selectable polarity.
module trigger_line_out #(
    parameter int DELAY_WIDTH      = 16,
    parameter int PULSE_WIDTH_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_trigger,
    input  logic                        i_line_en,
    input  logic                        i_line_active,
    input  logic [DELAY_WIDTH-1:0]      iv_delay,
    input  logic [PULSE_WIDTH_BITS-1:0] iv_width,
    output logic                        o_line,
    output logic                        o_busy,
    output logic                        o_trigger_miss
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                      state_reg, state_next;
    logic [DELAY_WIDTH-1:0]      dly_cnt_reg, dly_cnt_next;
    logic [PULSE_WIDTH_BITS-1:0] wid_cnt_reg, wid_cnt_next;
    logic [PULSE_WIDTH_BITS-1:0] wid_q_reg, wid_q_next;
    logic                        line_reg, line_next;
    logic                        busy_reg, busy_next;
    logic                        miss_reg, miss_next;
    logic [PULSE_WIDTH_BITS-1:0] width_eff;

    // A programmed width of zero still produces a one-cycle pulse.
    assign width_eff = (iv_width == '0) ? PULSE_WIDTH_BITS'(1) : iv_width;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            dly_cnt_reg <= '0;
            wid_cnt_reg <= '0;
            wid_q_reg   <= '0;
            line_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            miss_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dly_cnt_reg <= dly_cnt_next;
            wid_cnt_reg <= wid_cnt_next;
            wid_q_reg   <= wid_q_next;
            line_reg    <= line_next;
            busy_reg    <= busy_next;
            miss_reg    <= miss_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dly_cnt_next = dly_cnt_reg;
        wid_cnt_next = wid_cnt_reg;
        wid_q_next   = wid_q_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_trigger && i_line_en) begin
                    wid_q_next = width_eff;
                    if (iv_delay == '0) begin
                        state_next   = ST_ACTIVE;
                        wid_cnt_next = width_eff;
                    end else begin
                        state_next   = ST_DELAY;
                        dly_cnt_next = iv_delay;
                    end
                end
            end
            ST_DELAY: begin
                // Leaving on count 1 makes the assertion exactly D cycles later than D = 0.
                if (dly_cnt_reg == DELAY_WIDTH'(1)) begin
                    state_next   = ST_ACTIVE;
                    wid_cnt_next = wid_q_reg;
                end else begin
                    dly_cnt_next = dly_cnt_reg - DELAY_WIDTH'(1);
                end
            end
            ST_ACTIVE: begin
                if (wid_cnt_reg == PULSE_WIDTH_BITS'(1)) begin
                    state_next = ST_IDLE;
                end else begin
                    wid_cnt_next = wid_cnt_reg - PULSE_WIDTH_BITS'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!i_line_en) begin
            state_next = ST_IDLE;
        end
    end

    // Outputs lag the state by one register stage; disable overrides on the same edge.
    always_comb begin
        line_next = ~i_line_active;
        busy_next = 1'b0;
        miss_next = 1'b0;
        if (i_line_en) begin
            line_next = (state_reg == ST_ACTIVE) ~^ i_line_active;
            busy_next = (state_reg != ST_IDLE);
            miss_next = i_trigger && (state_reg != ST_IDLE);
        end
    end

    assign o_line         = line_reg;
    assign o_busy         = busy_reg;
    assign o_trigger_miss = miss_reg;

endmodule

// File: tb/tb_trigger_line_out.sv
// Directed bench for trigger_line_out: pulse timing, polarity, retrigger, abort and reset.
module tb_trigger_line_out;

    logic        clk;
    logic        rst_n;
    logic        i_trigger;
    logic        i_line_en;
    logic        i_line_active;
    logic [15:0] iv_delay;
    logic [15:0] iv_width;
    logic        o_line;
    logic        o_busy;
    logic        o_trigger_miss;

    int n_cmp;
    int n_err;

    trigger_line_out #(
        .DELAY_WIDTH     (16),
        .PULSE_WIDTH_BITS(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_trigger     (i_trigger),
        .i_line_en     (i_line_en),
        .i_line_active (i_line_active),
        .iv_delay      (iv_delay),
        .iv_width      (iv_width),
        .o_line        (o_line),
        .o_busy        (o_busy),
        .o_trigger_miss(o_trigger_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    initial begin
        logic exp_line;
        logic exp_busy;
        logic exp_miss;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_trigger = 1'b0;
        i_line_en = 1'b1;
        i_line_active = 1'b1;
        iv_delay = 16'd0;
        iv_width = 16'd1;

        // Reset values
        #12;
        chk("rst_line", 0, o_line, 1'b0);
        chk("rst_busy", 0, o_busy, 1'b0);
        chk("rst_miss", 0, o_trigger_miss, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        $display("reset released: line=%b busy=%b", o_line, o_busy);

        // Basic pulse: D=0, W=1
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("basic_line", k, o_line, k == 1);
            chk("basic_busy", k, o_busy, k == 1);
        end
        $display("basic pulse D=0 W=1 done");

        // D=5, W=3, width changed mid-delay
        iv_delay = 16'd5;
        iv_width = 16'd3;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) iv_width = 16'd100;
            tick();
            chk("dw_line", k, o_line, (k >= 6) && (k <= 8));
            chk("dw_busy", k, o_busy, (k >= 1) && (k <= 8));
        end
        $display("delay/width D=5 W=3 done");

        // Width zero, active-low, D=2
        iv_width = 16'd0;
        iv_delay = 16'd2;
        i_line_active = 1'b0;
        tick();
        chk("pol_idle", 0, o_line, 1'b1);
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("w0_line", k, o_line, !(k == 3));
        end
        $display("width zero active-low done");

        // Retrigger: D=4, W=4, triggers at k=0,2,8,9
        i_line_active = 1'b1;
        iv_delay = 16'd4;
        iv_width = 16'd4;
        tick();
        for (int k = 0; k <= 18; k++) begin
            i_trigger = (k == 0) || (k == 2) || (k == 8) || (k == 9);
            tick();
            i_trigger = 1'b0;
            exp_line = ((k >= 5) && (k <= 8)) || ((k >= 14) && (k <= 17));
            exp_busy = ((k >= 1) && (k <= 8)) || ((k >= 10) && (k <= 17));
            exp_miss = (k == 2) || (k == 8);
            chk("rt_line", k, o_line, exp_line);
            chk("rt_busy", k, o_busy, exp_busy);
            chk("rt_miss", k, o_trigger_miss, exp_miss);
        end
        $display("retrigger sequence done");

        // Abort during ACTIVE, trigger while disabled
        iv_delay = 16'd0;
        iv_width = 16'd10;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        tick();
        tick();
        chk("ab_line_pre", 2, o_line, 1'b1);
        i_line_en = 1'b0;
        tick();
        chk("ab_line", 3, o_line, 1'b0);
        chk("ab_busy", 3, o_busy, 1'b0);
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        chk("ab_miss", 4, o_trigger_miss, 1'b0);
        i_line_en = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            tick();
            chk("ab_noresume_line", k, o_line, 1'b0);
            chk("ab_noresume_busy", k, o_busy, 1'b0);
        end
        $display("abort done");

        // Async reset during DELAY, active-low line
        i_line_active = 1'b0;
        iv_delay = 16'd10;
        iv_width = 16'd2;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        tick();
        tick();
        chk("rm_busy_pre", 2, o_busy, 1'b1);
        chk("rm_line_pre", 2, o_line, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_line", 0, o_line, 1'b0);
        chk("rm_busy", 0, o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rm_first_line", 1, o_line, 1'b1);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk("rm_resid_line", k, o_line, 1'b1);
            chk("rm_resid_busy", k, o_busy, 1'b0);
        end
        $display("reset mid-operation done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
